// File: rtl/alu_operand_loader.sv
// Front-panel conditioner: synchronises and debounces KEY, turns presses into one-cycle events,
// and commits ALU operands/opcode from SW. Optional macro OPERAND_SIGN_EXT_EN enables sign-extended fill.
module alu_operand_loader #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned DATA_W          = 32
) (
  input  logic              CLOCK_50,
  input  logic              RST,
  input  logic [17:0]       SW,
  input  logic [3:0]        KEY,
  output logic [DATA_W-1:0] portA,
  output logic [DATA_W-1:0] portB,
  output logic [3:0]        aluOp,
  output logic              op_valid,
  output logic              ready,
  output logic [3:0]        key_pulse
);

  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HALF_W = 16;
  localparam int unsigned FILL_W = DATA_W - HALF_W;
  localparam int unsigned N_KEYS = 4;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    READY
  } state_t;

  state_t             state, state_d;
  logic [3:0]         k_s1, k_s2;
  logic [3:0]         stable, stable_d;
  logic [CNT_W-1:0]   cnt   [N_KEYS];
  logic [CNT_W-1:0]   cnt_d [N_KEYS];
  logic [3:0]         pulse_d;
  logic               flag_a, flag_b, flag_op;
  logic               flag_a_d, flag_b_d, flag_op_d;
  logic [DATA_W-1:0]  port_a_d, port_b_d;
  logic [3:0]         alu_op_d;
  logic               op_valid_d, ready_d;
  logic [FILL_W-1:0]  fill;
  logic [DATA_W-1:0]  operand;

  // Upper-half fill for operand loads
  always_comb begin
    fill = '0;
`ifdef OPERAND_SIGN_EXT_EN
    if (SW[16]) fill = {FILL_W{SW[15]}};
`else
    if (SW[16]) fill = '1;
`endif
    operand = {fill, SW[15:0]};
  end

  // Per-key debounce: a level change is accepted after DEBOUNCE_CYCLES consecutive differing samples
  always_comb begin
    stable_d = stable;
    pulse_d  = '0;
    for (int i = 0; i < int'(N_KEYS); i++) begin
      cnt_d[i] = '0;
      if (k_s2[i] != stable[i]) begin
        if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable_d[i] = k_s2[i];
          pulse_d[i]  = ~k_s2[i];
        end else begin
          cnt_d[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Event decode (clear > load operand > load opcode > execute) and flag-driven state
  always_comb begin
    port_a_d   = portA;
    port_b_d   = portB;
    alu_op_d   = aluOp;
    flag_a_d   = flag_a;
    flag_b_d   = flag_b;
    flag_op_d  = flag_op;
    op_valid_d = 1'b0;
    state_d    = state;

    if (key_pulse[3]) begin
      port_a_d  = '0;
      port_b_d  = '0;
      alu_op_d  = '0;
      flag_a_d  = 1'b0;
      flag_b_d  = 1'b0;
      flag_op_d = 1'b0;
    end else if (key_pulse[0]) begin
      if (SW[17]) begin
        port_b_d = operand;
        flag_b_d = 1'b1;
      end else begin
        port_a_d = operand;
        flag_a_d = 1'b1;
      end
    end else if (key_pulse[1]) begin
      alu_op_d  = SW[3:0];
      flag_op_d = 1'b1;
    end else if (key_pulse[2]) begin
      op_valid_d = (state == READY);
    end

    case ({flag_a_d, flag_b_d, flag_op_d})
      3'b000:  state_d = EMPTY;
      3'b111:  state_d = READY;
      default: state_d = PARTIAL;
    endcase
    ready_d = (state_d == READY);
  end

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      k_s1      <= '1;
      k_s2      <= '1;
      stable    <= '1;
      for (int i = 0; i < int'(N_KEYS); i++) cnt[i] <= '0;
      key_pulse <= '0;
      portA     <= '0;
      portB     <= '0;
      aluOp     <= '0;
      flag_a    <= 1'b0;
      flag_b    <= 1'b0;
      flag_op   <= 1'b0;
      op_valid  <= 1'b0;
      ready     <= 1'b0;
      state     <= EMPTY;
    end else begin
      k_s1      <= KEY;
      k_s2      <= k_s1;
      stable    <= stable_d;
      for (int i = 0; i < int'(N_KEYS); i++) cnt[i] <= cnt_d[i];
      key_pulse <= pulse_d;
      portA     <= port_a_d;
      portB     <= port_b_d;
      aluOp     <= alu_op_d;
      flag_a    <= flag_a_d;
      flag_b    <= flag_b_d;
      flag_op   <= flag_op_d;
      op_valid  <= op_valid_d;
      ready     <= ready_d;
      state     <= state_d;
    end
  end

endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
- Front-panel input conditioner that sits directly upstream of the ALU operand/opcode inputs in the FPGA build.
- Synchronises and debounces the four push buttons and turns each press into a single-cycle event.
- Uses those events to latch 32-bit operands A/B and the 4-bit ALU opcode from the switches, then issues a one-cycle execute strobe.
- Replaces direct switch/button wiring so the ALU only ever sees stable, deliberately committed values.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a button level change (10 ms at 50 MHz). Must be ≥ 2.
- DATA_W, 32, operand width. Fixed at 32 for this block.

Ports:
- CLOCK_50 input 1: sole clock, all logic on the rising edge.
- RST input 1: synchronous, active-high reset.
- SW input 18: SW[15:0] operand/opcode data; SW[16] upper-half fill select; SW[17] load target (0 = A, 1 = B).
- KEY input 4: push buttons, active-low raw.
  - KEY[0] = load operand.
  - KEY[1] = load opcode from SW[3:0].
  - KEY[2] = execute.
  - KEY[3] = clear.
- portA output 32: latched operand A.
- portB output 32: latched operand B.
- aluOp output 4: latched opcode.
- op_valid output 1: one-cycle execute strobe.
- ready output 1: A, B and opcode all loaded since the last clear.
- key_pulse output 4: debounced press events, one cycle each, for debug/LEDs.

Behaviour:
- Reset (RST high at an edge):
  - portA, portB and aluOp cleared to 0.
  - op_valid, ready and key_pulse cleared to 0.
  - Synchroniser flops set to 1 (released).
  - Debounced state set to released; debounce counters cleared to 0.
  - FSM goes to EMPTY.
  - Reset overrides every other event, including a reset asserted mid-debounce or mid-execute.
- Synchronisation: each KEY bit passes through 2 flops (k_s1, k_s2); no logic uses raw KEY.
- Debounce, per key, with counter width $clog2(DEBOUNCE_CYCLES):
  - If k_s2 == stable: counter ← 0.
  - Else if counter == DEBOUNCE_CYCLES-1: stable ← k_s2, counter ← 0.
  - Else: counter increments.
  - Any bounce back to the stable level restarts the count.
- Press event: key_pulse[i] is a registered 1 in the same cycle stable[i] goes 1→0. Releases produce no event.
- Latency: a key held low and first sampled low at edge t0 gives key_pulse high for exactly the cycle after edge t0+DEBOUNCE_CYCLES. Register updates appear after the next edge. Holding the key gives no repeats.
- Operand fill:
  - Loaded value = {fill, SW[15:0]}.
  - fill = 16'hFFFF if SW[16] is 1, else 16'h0000 (see optional feature).
- Event actions, priority KEY[3] > KEY[0] > KEY[1] > KEY[2] when pulses coincide. Only the highest-priority event acts; the others are dropped.
  - KEY[3]: clear portA/portB/aluOp to 0; FSM → EMPTY.
  - KEY[0]: SW[17]=0 loads portA and sets the a flag; SW[17]=1 loads portB and sets the b flag.
  - KEY[1]: aluOp ← SW[3:0]; sets the op flag.
  - KEY[2]: in READY, op_valid = 1 for one cycle and the FSM stays READY. In any other state it is ignored and op_valid stays 0.
- FSM states: EMPTY (no flags), PARTIAL (some flags), READY (a, b and op flags all set).
  - Transitions are recomputed from the flags on each event.
  - A reload while READY stays READY and updates the value.
  - ready = (state == READY).
- Outputs are registered. portA, portB and aluOp hold their value between events.

Optional Feature:
- Macro: OPERAND_SIGN_EXT_EN.
- Defined: when SW[16]=1, fill = {16{SW[15]}} (true sign extension); when SW[16]=0, fill = 16'h0000.
- Undefined: when SW[16]=1, fill = 16'hFFFF regardless of SW[15].

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4.
- Reset → all outputs 0, state EMPTY; then KEY[2] press → op_valid stays 0.
- KEY[0] low 2 cycles, high 1, low 2 (bounce) → no key_pulse. KEY[0] then held low → key_pulse[0] high exactly 1 cycle, 4 cycles after the first low sample; held 20 cycles → no second pulse.
- Load sequence:
  - SW=18'h0_1234 then KEY[0] → portA = 32'h0000_1234.
  - SW=18'h3_8001 then KEY[0] → portB = 32'hFFFF_8001 in both builds; with SW=18'h3_0001 → 32'hFFFF_0001 (undefined) vs 32'h0000_0001 (OPERAND_SIGN_EXT_EN).
  - SW[3:0]=4'h5 then KEY[1] → aluOp = 5, ready = 1.
- READY, KEY[2] press → op_valid = 1 for exactly 1 cycle, ready stays 1.
- KEY[3] and KEY[0] pulses in the same cycle → clear wins: portA = portB = 0, aluOp = 0, ready = 0.
- RST asserted mid-debounce (counter = 2) with key still low → counters cleared; pulse arrives only after a full new 4-cycle window following RST deassertion.
